bus_ctrl: RTL and testbench
===========================

BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 SHALL have parameter DM_MAX, default 32'h0000_2FFF, last valid data-memory byte address (DM base 0).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum DM wait cycles before bus error.
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request, held until cpu_done.
- cpu_we  in  1  1=store, 0=load.
- cpu_size  in  2  0=byte, 1=half, 2=word; 3 illegal.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, low-aligned.
- cpu_stall  out  1  pipeline freeze.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  raw word read, valid with cpu_done.
- adel / ades  out  1 each  load / store exception, valid with cpu_done.
- dm_en, dm_we  out  1 each  DM access strobe, write enable.
- dm_be  out  4  DM byte enables.
- dm_addr  out  32  word-aligned DM address.
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  DM read word.
- dm_ready  in  1  DM completion.
- tc_sel  out  2  one-hot timer select (bit0 TC0, bit1 TC1).
- tc_we  out  1  timer write strobe.
- tc_addr  out  2  timer register index (addr[3:2]).
- tc0_rdata, tc1_rdata  in  32 each  timer read words.

Function
REQ-004 SHALL implement FSM IDLE, DM_WAIT, DONE.
REQ-005 SHALL decode regions: DM 0..DM_MAX, TC0 0x7F00..0x7F0B, TC1 0x7F10..0x7F1B; everything else unmapped.
REQ-006 SHALL flag an exception when: size 3; word with addr[1:0]!=0; half with addr[0]!=0; unmapped; timer access of non-word size; store to timer register index 2.
REQ-007 SHALL, in IDLE with cpu_req=1 and an exception, go to DONE with no DM or timer strobe; in DONE, adel=~cpu_we, ades=cpu_we.
REQ-008 SHALL, in IDLE for a legal timer access, assert tc_sel/tc_addr (and tc_we for stores) for exactly the next cycle, capture the selected tc rdata in that cycle, and pulse cpu_done in the cycle after (latency 2 from accept).
REQ-009 SHALL, in IDLE for a legal DM access, register dm_addr={addr[31:2],2'b00}, dm_we, dm_be, dm_wdata and enter DM_WAIT with dm_en=1.
REQ-010 SHALL hold all dm_* outputs stable in DM_WAIT until dm_ready is sampled high, then capture dm_rdata, deassert dm_en and enter DONE.
REQ-011 SHALL count DM_WAIT cycles; on reaching TIMEOUT without dm_ready, drop dm_en and enter DONE with the exception flag for that access type.
REQ-012 SHALL generate dm_be: word 4'b1111; half 4'b0011 or 4'b1100 by addr[1]; byte 4'b0001<<addr[1:0]; loads use the same mask.
REQ-013 SHALL replicate store data: half {2{wdata[15:0]}}, byte {4{wdata[7:0]}}, word unchanged.
REQ-014 SHALL pulse cpu_done exactly one cycle in DONE, then return to IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-015 SHALL drive cpu_stall = cpu_req & ~cpu_done (combinational).
REQ-016 SHALL return cpu_rdata as the raw captured word; sign/zero extension and lane selection are downstream.
REQ-017 SHALL hold cpu_rdata, adel, ades at 0 in every cycle other than DONE.
REQ-018 SHALL ignore changes on cpu_* inputs outside IDLE; captured request governs the access.

Reset
REQ-019 SHALL on reset force IDLE, wait counter 0, and all outputs 0 (dm_be 0, tc_sel 0), regardless of clock, aborting any in-flight DM or timer access.
REQ-020 SHALL accept a request no earlier than the first rising edge after reset deasserts.

Verification
REQ-021 Word load addr 0x10, dm_ready after 3 cycles, dm_rdata 0xDEADBEEF -> dm_en high 3 cycles, cpu_done next cycle, cpu_rdata 0xDEADBEEF, stall drops with done.
REQ-022 Byte store addr 0x23, wdata 0x000000A5 -> dm_be 4'b1000, dm_wdata 0xA5A5A5A5, dm_we 1, ades 0.
REQ-023 Half load addr 0x7F01 / word store addr 0x7F08 / word load 0x3000 -> no strobes, cpu_done 1 cycle after accept, adel / ades / adel respectively.
REQ-024 Word store 0x7F14, wdata 0x55 -> tc_sel 2'b10, tc_addr 1, tc_we 1 for one cycle, cpu_done next cycle, ades 0.
REQ-025 DM load with dm_ready held 0 -> dm_en drops after 15 cycles, cpu_done with adel 1.
REQ-026 Reset asserted mid DM_WAIT -> all outputs 0 immediately, next request served normally.

Source files
------------

// File: rtl/bus_ctrl_if.sv
// Signal bundle between the CPU, the bus controller, data memory and the two timers.
// master is the controller's view; slave is the CPU/memory/timer side.
interface bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        adel;
  logic        ades;
  logic        dm_en;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic [1:0]  tc_sel;
  logic        tc_we;
  logic [1:0]  tc_addr;
  logic [31:0] tc0_rdata;
  logic [31:0] tc1_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    input  dm_rdata, dm_ready, tc0_rdata, tc1_rdata,
    output cpu_stall, cpu_done, cpu_rdata, adel, ades,
    output dm_en, dm_we, dm_be, dm_addr, dm_wdata,
    output tc_sel, tc_we, tc_addr
  );

  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    output dm_rdata, dm_ready, tc0_rdata, tc1_rdata,
    input  cpu_stall, cpu_done, cpu_rdata, adel, ades,
    input  dm_en, dm_we, dm_be, dm_addr, dm_wdata,
    input  tc_sel, tc_we, tc_addr
  );
endinterface

// File: rtl/bus_ctrl.sv
// CPU load/store controller: decodes DM / timer regions, flags address exceptions,
// runs DM accesses with a bounded wait and returns one-cycle completion pulses.
module bus_ctrl #(
  parameter logic [31:0] DM_MAX  = 32'h0000_2FFF,
  parameter int unsigned TIMEOUT = 15
) (
  input logic        clk,
  input logic        reset,
  bus_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DM_WAIT, DONE} stateT;

  typedef struct packed {
    logic        dmEn;
    logic        dmWe;
    logic [3:0]  dmBe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic [1:0]  tcSel;
    logic        tcWe;
    logic [1:0]  tcAddr;
    logic        done;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
  } outT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] waitCnt, waitCntNext;
  outT              outQ, outD;

  logic        isTc0, isTc1, isTc, isDm, misaligned, excReq;
  logic [3:0]  beReq;
  logic [31:0] wdataRep;

  always_comb begin
    isTc0 = (bus.cpu_addr >= 32'h0000_7F00) && (bus.cpu_addr <= 32'h0000_7F0B);
    isTc1 = (bus.cpu_addr >= 32'h0000_7F10) && (bus.cpu_addr <= 32'h0000_7F1B);
    isTc  = isTc0 | isTc1;
    isDm  = !isTc && (bus.cpu_addr <= DM_MAX);
    misaligned = 1'b0;
    beReq      = 4'b1111;
    wdataRep   = bus.cpu_wdata;
    case (bus.cpu_size)
      2'd0: begin
        beReq    = 4'b0001 << bus.cpu_addr[1:0];
        wdataRep = {4{bus.cpu_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = bus.cpu_addr[0];
        beReq      = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdataRep   = {2{bus.cpu_wdata[15:0]}};
      end
      2'd2:    misaligned = |bus.cpu_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    excReq = misaligned || !(isDm || isTc) ||
             (isTc && ((bus.cpu_size != 2'd2) || (bus.cpu_we && bus.cpu_addr[3:2] == 2'd2)));
  end

  // Timer accesses reuse DM_WAIT for their single strobe cycle; a nonzero tcSel marks them.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    outD        = outQ;
    outD.done   = 1'b0;
    outD.rdata  = '0;
    outD.adel   = 1'b0;
    outD.ades   = 1'b0;
    case (state)
      IDLE: begin
        waitCntNext = '0;
        if (bus.cpu_req) begin
          if (excReq) begin
            stateNext = DONE;
            outD.done = 1'b1;
            outD.adel = ~bus.cpu_we;
            outD.ades = bus.cpu_we;
          end else if (isTc) begin
            stateNext   = DM_WAIT;
            outD.tcSel  = {isTc1, isTc0};
            outD.tcAddr = bus.cpu_addr[3:2];
            outD.tcWe   = bus.cpu_we;
          end else begin
            stateNext    = DM_WAIT;
            outD.dmEn    = 1'b1;
            outD.dmWe    = bus.cpu_we;
            outD.dmBe    = beReq;
            outD.dmAddr  = {bus.cpu_addr[31:2], 2'b00};
            outD.dmWdata = wdataRep;
          end
        end
      end
      DM_WAIT: begin
        if (outQ.tcSel != 2'b00) begin
          stateNext  = DONE;
          outD.rdata = outQ.tcSel[0] ? bus.tc0_rdata : bus.tc1_rdata;
        end else if (bus.dm_ready) begin
          stateNext  = DONE;
          outD.rdata = bus.dm_rdata;
        end else if (waitCnt == LAST_WAIT) begin
          stateNext = DONE;
          outD.adel = ~outQ.dmWe;
          outD.ades = outQ.dmWe;
        end else begin
          waitCntNext = waitCnt + CNT_W'(1);
        end
        if (stateNext == DONE) begin
          outD.done    = 1'b1;
          outD.dmEn    = 1'b0;
          outD.dmWe    = 1'b0;
          outD.dmBe    = '0;
          outD.dmAddr  = '0;
          outD.dmWdata = '0;
          outD.tcSel   = '0;
          outD.tcWe    = 1'b0;
          outD.tcAddr  = '0;
        end
      end
      DONE: begin
        stateNext   = IDLE;
        waitCntNext = '0;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      outQ    <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      outQ    <= outD;
    end
  end

  assign bus.dm_en     = outQ.dmEn;
  assign bus.dm_we     = outQ.dmWe;
  assign bus.dm_be     = outQ.dmBe;
  assign bus.dm_addr   = outQ.dmAddr;
  assign bus.dm_wdata  = outQ.dmWdata;
  assign bus.tc_sel    = outQ.tcSel;
  assign bus.tc_we     = outQ.tcWe;
  assign bus.tc_addr   = outQ.tcAddr;
  assign bus.cpu_done  = outQ.done;
  assign bus.cpu_rdata = outQ.rdata;
  assign bus.adel      = outQ.adel;
  assign bus.ades      = outQ.ades;
  assign bus.cpu_stall = bus.cpu_req & ~outQ.done;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: a transaction-level model predicts every cycle of each
// access into a queue, and one negedge process compares the DUT against it.
module tb_bus_ctrl;
  localparam logic [31:0] DM_MAX  = 32'h0000_2FFF;
  localparam int          TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   skipCmp = 1'b0;
  int   nTests = 0;
  int   nFail  = 0;

  bus_ctrl_if bus ();

  bus_ctrl #(.DM_MAX(DM_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic        adel;
    logic        ades;
    logic [31:0] rdata;
    logic        dmEn;
    logic        dmWe;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  tcSel;
    logic        tcWe;
    logic [1:0]  tcAddr;
  } expT;

  typedef struct {
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          lat;
  } vecT;

  expT expQ[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isTimer(input logic [31:0] a);
    return (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
  endfunction

  function automatic bit modelExc(input bit we, input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd2 && a % 4 != 0) return 1'b1;
    if (size == 2'd1 && a % 2 != 0) return 1'b1;
    if (!isTimer(a) && a > DM_MAX) return 1'b1;
    if (isTimer(a) && (size != 2'd2 || (we && (a % 16) / 4 == 2))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return 4'(1 << (a % 4));
    if (size == 2'd1) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] modelRep(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
    if (size == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic expT sampleDut();
    expT s;
    s.done   = bus.cpu_done;
    s.adel   = bus.adel;
    s.ades   = bus.ades;
    s.rdata  = bus.cpu_rdata;
    s.dmEn   = bus.dm_en;
    s.dmWe   = bus.dm_we;
    s.be     = bus.dm_be;
    s.addr   = bus.dm_addr;
    s.wdata  = bus.dm_wdata;
    s.tcSel  = bus.tc_sel;
    s.tcWe   = bus.tc_we;
    s.tcAddr = bus.tc_addr;
    return s;
  endfunction

  // Per-cycle comparison against the queued prediction; an empty queue means idle.
  always @(negedge clk) begin
    expT e;
    if (!reset && !skipCmp) begin
      e = '0;
      if (expQ.size() > 0) e = expQ.pop_front();
      chk("done/adel/ades", 128'({bus.cpu_done, bus.adel, bus.ades}), 128'({e.done, e.adel, e.ades}));
      chk("cpu_rdata", 128'(bus.cpu_rdata), 128'(e.rdata));
      chk("dm_en", 128'(bus.dm_en), 128'(e.dmEn));
      if (e.dmEn)
        chk("dm we/be/addr/wdata", 128'({bus.dm_we, bus.dm_be, bus.dm_addr, bus.dm_wdata}),
            128'({e.dmWe, e.be, e.addr, e.wdata}));
      chk("tc_sel/tc_we", 128'({bus.tc_sel, bus.tc_we}), 128'({e.tcSel, e.tcWe}));
      if (e.tcSel != 2'b00) chk("tc_addr", 128'(bus.tc_addr), 128'(e.tcAddr));
      chk("cpu_stall", 128'(bus.cpu_stall), 128'(bus.cpu_req & ~e.done));
    end
  end

  task automatic doAccess(input vecT v, output int enCnt, output expT first, output expT last);
    expT         e;
    int          n;
    int          waits;
    bit          exc, tc, dm, ok;
    logic [31:0] t0, t1;
    @(negedge clk); #1;
    t0 = $urandom;
    t1 = $urandom;
    bus.tc0_rdata = t0;
    bus.tc1_rdata = t1;
    exc = modelExc(v.we, v.size, v.addr);
    tc  = !exc && isTimer(v.addr);
    dm  = !exc && !tc;
    e = '0;
    if (exc) begin
      e.done = 1'b1; e.adel = !v.we; e.ades = v.we;
      expQ.push_back(e);
      n = 1;
    end else if (tc) begin
      e.tcSel  = (v.addr >= 32'h7F10) ? 2'b10 : 2'b01;
      e.tcAddr = 2'((v.addr % 16) / 4);
      e.tcWe   = v.we;
      expQ.push_back(e);
      e = '0;
      e.done  = 1'b1;
      e.rdata = (v.addr >= 32'h7F10) ? t1 : t0;
      expQ.push_back(e);
      n = 2;
    end else begin
      ok      = v.lat >= 1 && v.lat <= TIMEOUT;
      waits   = ok ? v.lat : TIMEOUT;
      e.dmEn  = 1'b1;
      e.dmWe  = v.we;
      e.be    = modelBe(v.size, v.addr);
      e.addr  = v.addr - v.addr % 4;
      e.wdata = modelRep(v.size, v.wdata);
      repeat (waits) expQ.push_back(e);
      e = '0;
      e.done = 1'b1;
      if (ok) e.rdata = v.rword;
      else begin e.adel = !v.we; e.ades = v.we; end
      expQ.push_back(e);
      n = waits + 1;
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = v.we;
    bus.cpu_size  = v.size;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    enCnt = 0;
    first = '0;
    last  = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk); #1;
      if (bus.dm_en) enCnt++;
      if (c == 1) first = sampleDut();
      if (c == n) last = sampleDut();
      if (c == 1) begin
        bus.cpu_we    = ~v.we;
        bus.cpu_size  = 2'($urandom);
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
      end
      bus.dm_ready = dm && (c == v.lat);
      bus.dm_rdata = (c == v.lat) ? v.rword : $urandom;
      if (c == n) bus.cpu_req = 1'b0;
    end
    bus.dm_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecT  vecs[$];
    vecT  v;
    int   enCnt;
    expT  first, last;

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = '0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.dm_rdata = '0; bus.dm_ready = 1'b0;
    bus.tc0_rdata = '0; bus.tc1_rdata = '0;

    // Pin the model to hand-computed values.
    chk("model be byte@23", 128'(modelBe(2'd0, 32'h23)), 128'(4'b1000));
    chk("model be half@102", 128'(modelBe(2'd1, 32'h102)), 128'(4'b1100));
    chk("model rep byte", 128'(modelRep(2'd0, 32'hA5)), 128'(32'hA5A5A5A5));
    chk("model rep half", 128'(modelRep(2'd1, 32'h1234)), 128'(32'h12341234));
    chk("model exc half 7F01", 128'(modelExc(1'b0, 2'd1, 32'h7F01)), 128'(1));
    chk("model exc st 7F08", 128'(modelExc(1'b1, 2'd2, 32'h7F08)), 128'(1));
    chk("model exc ld 7F08", 128'(modelExc(1'b0, 2'd2, 32'h7F08)), 128'(0));
    chk("model exc ld 3000", 128'(modelExc(1'b0, 2'd2, 32'h3000)), 128'(1));

    #12;
    chk("reset state", 128'(sampleDut()), 128'(0));
    #5 reset = 1'b0;

    v = '{we:1'b0, size:2'd2, addr:32'h10, wdata:32'h0, rword:32'hDEADBEEF, lat:3};
    doAccess(v, enCnt, first, last);
    chk("word load dm_en cycles", 128'(enCnt), 128'(3));
    chk("word load rdata", 128'({last.done, last.rdata}), 128'({1'b1, 32'hDEADBEEF}));

    v = '{we:1'b1, size:2'd0, addr:32'h23, wdata:32'hA5, rword:32'h0, lat:2};
    doAccess(v, enCnt, first, last);
    chk("byte store be/wdata/we", 128'({first.be, first.wdata, first.dmWe}),
        128'({4'b1000, 32'hA5A5A5A5, 1'b1}));
    chk("byte store ades", 128'({last.done, last.ades}), 128'({1'b1, 1'b0}));

    v = '{we:1'b0, size:2'd1, addr:32'h7F01, wdata:32'h0, rword:32'h0, lat:1};
    doAccess(v, enCnt, first, last);
    chk("half load 7F01 adel", 128'({enCnt, last.done, last.adel, last.ades}), 128'({32'd0, 3'b110}));
    v = '{we:1'b1, size:2'd2, addr:32'h7F08, wdata:32'h1, rword:32'h0, lat:1};
    doAccess(v, enCnt, first, last);
    chk("word store 7F08 ades", 128'({last.done, last.adel, last.ades, last.tcSel}), 128'({3'b101, 2'b00}));
    v = '{we:1'b0, size:2'd2, addr:32'h3000, wdata:32'h0, rword:32'h0, lat:1};
    doAccess(v, enCnt, first, last);
    chk("word load 3000 adel", 128'({enCnt, last.done, last.adel, last.ades}), 128'({32'd0, 3'b110}));

    v = '{we:1'b1, size:2'd2, addr:32'h7F14, wdata:32'h55, rword:32'h0, lat:1};
    doAccess(v, enCnt, first, last);
    chk("timer store strobe", 128'({first.tcSel, first.tcAddr, first.tcWe}), 128'({2'b10, 2'd1, 1'b1}));
    chk("timer store done", 128'({last.done, last.ades}), 128'({1'b1, 1'b0}));

    v = '{we:1'b0, size:2'd2, addr:32'h20, wdata:32'h0, rword:32'h0, lat:0};
    doAccess(v, enCnt, first, last);
    chk("timeout dm_en cycles", 128'(enCnt), 128'(TIMEOUT));
    chk("timeout adel", 128'({last.done, last.adel, last.ades}), 128'(3'b110));

    vecs.push_back('{we:1'b1, size:2'd1, addr:32'h102,  wdata:32'hFFFF1234, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b0, size:2'd1, addr:32'h100,  wdata:32'h0, rword:32'h0BADF00D, lat:2});
    vecs.push_back('{we:1'b0, size:2'd0, addr:32'h2FFF, wdata:32'h0, rword:32'h11223344, lat:TIMEOUT});
    vecs.push_back('{we:1'b0, size:2'd2, addr:32'h2FFC, wdata:32'h0, rword:32'hCAFEF00D, lat:1});
    vecs.push_back('{we:1'b1, size:2'd2, addr:32'h44,   wdata:32'h89ABCDEF, rword:32'h0, lat:4});
    vecs.push_back('{we:1'b0, size:2'd0, addr:32'h3000, wdata:32'h0, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b0, size:2'd2, addr:32'h7F04, wdata:32'h0, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b0, size:2'd2, addr:32'h7F18, wdata:32'h0, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b1, size:2'd2, addr:32'h7F10, wdata:32'h77, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b1, size:2'd2, addr:32'h7F18, wdata:32'h1, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b0, size:2'd0, addr:32'h7F00, wdata:32'h0, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b0, size:2'd3, addr:32'h40,   wdata:32'h0, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b1, size:2'd2, addr:32'h12,   wdata:32'h5, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b0, size:2'd1, addr:32'h11,   wdata:32'h0, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b0, size:2'd2, addr:32'h7F0C, wdata:32'h0, rword:32'h0, lat:1});
    vecs.push_back('{we:1'b1, size:2'd0, addr:32'h31,   wdata:32'h3C, rword:32'h0, lat:0});
    foreach (vecs[i]) doAccess(vecs[i], enCnt, first, last);

    // Asynchronous reset in the middle of a DM wait.
    skipCmp = 1'b1;
    @(negedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'd2; bus.cpu_addr = 32'h80;
    bus.dm_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("dm_en before reset", 128'(bus.dm_en), 128'(1));
    #2 reset = 1'b1;
    #1 chk("outputs in reset", 128'(sampleDut()), 128'(0));
    bus.cpu_req = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    skipCmp = 1'b0;

    v = '{we:1'b0, size:2'd2, addr:32'h40, wdata:32'h0, rword:32'h13579BDF, lat:2};
    doAccess(v, enCnt, first, last);
    chk("load after reset", 128'({enCnt, last.done, last.rdata}), 128'({32'd2, 1'b1, 32'h13579BDF}));

    repeat (3) @(negedge clk);
    chk("prediction queue drained", 128'(expQ.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
